// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus widths, DMA state encoding and tristate constants
// Purpose: common definitions for the bus-master DMA engine and its helpers.
// Contents: default widths, dma_state_t (IDLE=0, REQ=1, RD=2, WR=3, DONE=4),
//           high-impedance constants for releasing the shared bus.
package bus_pkg;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } dma_state_t;

  localparam logic                  BIT_Z  = 1'bz;
  localparam logic [DEF_ADDR_W-1:0] ADDR_Z = {DEF_ADDR_W{1'bz}};
  localparam logic [DEF_DATA_W-1:0] DATA_Z = {DEF_DATA_W{1'bz}};

endpackage

// File: rtl/dma_addr_gen.sv
// rtl/dma_addr_gen.sv - source/destination pointers and remaining-word counter
// Purpose: holds the transfer pointers; loads on start, advances on each committed write.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   load              capture src_in/dst_in/len_in
//   step              one word committed: pointers +1 (mod 2^ADDR_W), remaining -1
//   src_in, dst_in    start addresses
//   len_in            word count
//   src_ptr, dst_ptr  current word addresses
//   last              remaining == 1
module dma_addr_gen #(
  parameter int ADDR_W = 20,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src_in,
  input  logic [ADDR_W-1:0] dst_in,
  input  logic [LEN_W-1:0]  len_in,
  output logic [ADDR_W-1:0] src_ptr,
  output logic [ADDR_W-1:0] dst_ptr,
  output logic              last
);

  logic [LEN_W-1:0] remaining;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
    end else if (load) begin
      src_ptr   <= src_in;
      dst_ptr   <= dst_in;
      remaining <= len_in;
    end else if (step && (remaining != '0)) begin
      // Pointers wrap silently at the top of the address space.
      src_ptr   <= src_ptr + ADDR_W'(1);
      dst_ptr   <= dst_ptr + ADDR_W'(1);
      remaining <= remaining - LEN_W'(1);
    end
  end

  assign last = (remaining == LEN_W'(1));

endmodule

// File: rtl/dma_copy_engine.sv
// rtl/dma_copy_engine.sv - bus-master DMA block copy over the shared tristate bus
// Purpose: copies length words from src_addr to dst_addr, one RD then one WR per word,
//          arbitrating for the bus with bus_req/bus_grant.
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   start                        1-cycle request, sampled only in IDLE
//   src_addr, dst_addr, length   transfer parameters, latched on start
//   fill_mode, fill_value        (DMA_FILL_EN only) write fill_value instead of copying
//   bus_grant                    arbiter grant; gates every bus driver combinationally
//   bus_req                      bus request (REQ/RD/WR)
//   busy                         state != IDLE
//   done                         1-cycle completion pulse
//   bus_addr, read, write        tristate bus controls, driven only while owning the bus
//   bus_data                     tristate data, driven only in WR while granted
// Configuration: define DMA_FILL_EN to add the fill-mode ports and behaviour.
module dma_copy_engine
  import bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
`ifdef DMA_FILL_EN
  input  logic              fill_mode,
  input  logic [DATA_W-1:0] fill_value,
`endif
  input  logic              bus_grant,
  output logic              bus_req,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              read,
  output logic              write,
  inout  wire  [DATA_W-1:0] bus_data
);

  dma_state_t        state, state_nx;
  logic              load, step, latch_data, last;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] wr_data;
  logic              skip_rd;
  logic              drive_en;

  dma_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .src_in  (src_addr),
    .dst_in  (dst_addr),
    .len_in  (length),
    .src_ptr (src_ptr),
    .dst_ptr (dst_ptr),
    .last    (last)
  );

`ifdef DMA_FILL_EN
  logic              fill_q;
  logic [DATA_W-1:0] fill_val_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_q     <= 1'b0;
      fill_val_q <= '0;
    end else if (load) begin
      fill_q     <= fill_mode;
      fill_val_q <= fill_value;
    end
  end

  // Fill transfers never read: REQ goes straight to WR and WR loops on itself.
  assign skip_rd = fill_q;
  assign wr_data = fill_q ? fill_val_q : data_reg;
`else
  assign skip_rd = 1'b0;
  assign wr_data = data_reg;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bus_req    = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    latch_data = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (length != '0) begin
            load     = 1'b1;
            state_nx = ST_REQ;
          end else begin
            state_nx = ST_DONE;
          end
        end
      end
      ST_REQ: begin
        bus_req = 1'b1;
        if (bus_grant) begin
          state_nx = skip_rd ? ST_WR : ST_RD;
        end
      end
      ST_RD: begin
        bus_req = 1'b1;
        if (bus_grant) begin
          latch_data = 1'b1;
          state_nx   = ST_WR;
        end else begin
          state_nx = ST_REQ;
        end
      end
      ST_WR: begin
        bus_req = 1'b1;
        if (bus_grant) begin
          step = 1'b1;
          if (last) begin
            state_nx = ST_DONE;
          end else begin
            state_nx = skip_rd ? ST_WR : ST_RD;
          end
        end else begin
          // Word not committed; data_reg is re-read from the source on retry.
          state_nx = ST_REQ;
        end
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg <= '0;
    end else if (latch_data) begin
      data_reg <= bus_data;
    end
  end

  assign busy = (state != ST_IDLE);

  // Ownership is combinational on bus_grant so the bus is released the instant grant drops.
  assign drive_en = ((state == ST_RD) || (state == ST_WR)) && bus_grant;

  assign bus_addr = drive_en ? ((state == ST_WR) ? dst_ptr : src_ptr) : {ADDR_W{BIT_Z}};
  assign read     = drive_en ? (state == ST_RD) : BIT_Z;
  assign write    = drive_en ? (state == ST_WR) : BIT_Z;
  assign bus_data = (drive_en && (state == ST_WR)) ? wr_data : {DATA_W{BIT_Z}};

endmodule

// File: tb/tb_dma_copy_engine.sv
// tb/tb_dma_copy_engine.sv - self-checking bench for dma_copy_engine
module tb_dma_copy_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [19:0] src_addr, dst_addr;
  logic [15:0] length;
  logic        bus_grant;
  wire         bus_req, busy, done;
  wire  [19:0] bus_addr;
  wire         read, write;
  wire  [15:0] bus_data;
`ifdef DMA_FILL_EN
  logic        fill_mode;
  logic [15:0] fill_value;
`endif

  // Released read/write float high together; the engine never drives both high.
  pullup (read);
  pullup (write);

  dma_copy_engine dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
`ifdef DMA_FILL_EN
    .fill_mode  (fill_mode),
    .fill_value (fill_value),
`endif
    .bus_grant  (bus_grant),
    .bus_req    (bus_req),
    .busy       (busy),
    .done       (done),
    .bus_addr   (bus_addr),
    .read       (read),
    .write      (write),
    .bus_data   (bus_data)
  );

  always #5 clk = ~clk;

  // Data memory: asynchronous read, synchronous write.
  logic [15:0] mem [0:(1<<20)-1];
  assign bus_data = (read === 1'b1 && write === 1'b0) ? mem[bus_addr] : 16'hzzzz;
  always @(posedge clk) begin
    if (reset !== 1'b1 && write === 1'b1 && read === 1'b0) mem[bus_addr] <= bus_data;
  end

  function automatic logic [15:0] init_val(input logic [19:0] a);
    return a[15:0] + 16'h1000;
  endfunction

  // Model: expected memory contents and expected ordered list of granted bus operations.
  typedef struct {
    bit          wr;
    logic [19:0] addr;
    logic [15:0] data;
  } bus_op_t;

  bus_op_t     ops[$];
  logic [15:0] model_wr [int];
  logic [19:0] rd_addrs[$];

  int  n_checks = 0;
  int  n_fail = 0;
  bit  chk_on = 1'b0;
  bit  ops_check = 1'b1;
  bit  expect_float = 1'b0;
  int  last_done_edge, last_busy_cnt;
  bit  saw_req, saw_read;

  function automatic logic [15:0] model_rd(input logic [19:0] a);
    if (model_wr.exists(int'(a))) return model_wr[int'(a)];
    return init_val(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic build_ops(input logic [19:0] s, input logic [19:0] d, input int n,
                           input bit fm, input logic [15:0] fv);
    bus_op_t op;
    logic [15:0] v;
    for (int i = 0; i < n; i++) begin
      if (fm) begin
        v = fv;
      end else begin
        v = model_rd(s + 20'(i));
        op.wr = 1'b0; op.addr = s + 20'(i); op.data = '0;
        ops.push_back(op);
      end
      op.wr = 1'b1; op.addr = d + 20'(i); op.data = v;
      ops.push_back(op);
      model_wr[int'(d + 20'(i))] = v;
    end
  endtask

  // Compare process: every cycle the bus is either released or carries the next expected op.
  always @(negedge clk) begin
    if (chk_on) begin
      automatic bit floating = (read === 1'b1 && write === 1'b1);
      automatic bus_op_t op;
      if (reset === 1'b1 || bus_grant !== 1'b1 || expect_float) begin
        chk("bus_released", {31'd0, floating}, 32'd1);
      end else if (!floating && ops_check) begin
        chk("bus_req_while_driving", {31'd0, bus_req}, 32'd1);
        if (ops.size() == 0) begin
          chk("unexpected_bus_op", 32'd1, 32'd0);
        end else begin
          op = ops.pop_front();
          chk("op_write", {31'd0, write}, {31'd0, op.wr});
          chk("op_read", {31'd0, read}, {31'd0, !op.wr});
          chk("op_addr", {12'd0, bus_addr}, {12'd0, op.addr});
          if (op.wr) chk("op_wdata", {16'd0, bus_data}, {16'd0, op.data});
        end
      end
    end
  end

  task automatic run_xfer(input logic [19:0] s, input logic [19:0] d, input logic [15:0] n,
                          input bit fm, input logic [15:0] fv);
    build_ops(s, d, int'(n), fm, fv);
    rd_addrs.delete();
    saw_req = 1'b0;
    saw_read = 1'b0;
    @(posedge clk); #1;
    src_addr = s; dst_addr = d; length = n; start = 1'b1;
`ifdef DMA_FILL_EN
    fill_mode = fm; fill_value = fv;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    last_done_edge = -1;
    last_busy_cnt = 0;
    for (int k = 1; k <= 300 && last_done_edge < 0; k++) begin
      @(negedge clk);
      if (busy === 1'b1) last_busy_cnt++;
      if (bus_req === 1'b1) saw_req = 1'b1;
      if (read === 1'b1 && write === 1'b0) begin
        saw_read = 1'b1;
        rd_addrs.push_back(bus_addr);
      end
      if (done === 1'b1) last_done_edge = k;
    end
    if (last_done_edge < 0) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
    chk("ops_drained", 32'(ops.size()), 32'd0);
    for (int i = 0; i < int'(n); i++)
      chk("mem_contents", {16'd0, mem[d + 20'(i)]}, {16'd0, model_rd(d + 20'(i))});
    ops.delete();
  endtask

  bit dropped;

  initial begin
    for (int i = 0; i < (1 << 20); i++) mem[i] = init_val(20'(i));
    reset = 1'b1; start = 1'b0; bus_grant = 1'b1;
    src_addr = '0; dst_addr = '0; length = '0;
`ifdef DMA_FILL_EN
    fill_mode = 1'b0; fill_value = '0;
`endif
    chk_on = 1'b1;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_bus_req", {31'd0, bus_req}, 32'd0);
    chk("reset_released", {30'd0, read, write}, 32'd3);
    @(posedge clk); #1;
    reset = 1'b0;

    // Plain copy with grant held.
    run_xfer(20'h00010, 20'h00100, 16'd4, 1'b0, 16'h0);
    chk("copy_done_edge", 32'(last_done_edge), 32'd10);
    chk("copy_busy_cycles", 32'(last_busy_cnt), 32'd10);
    chk("copy_word0", {16'd0, mem[20'h00100]}, 32'h1010);
    chk("copy_word3", {16'd0, mem[20'h00103]}, 32'h1013);

    // Zero length: immediate done, no bus activity.
    expect_float = 1'b1;
    run_xfer(20'h00020, 20'h00700, 16'd0, 1'b0, 16'h0);
    expect_float = 1'b0;
    chk("len0_done_edge", 32'(last_done_edge), 32'd1);
    chk("len0_busy_cycles", 32'(last_busy_cnt), 32'd1);
    chk("len0_no_bus_req", {31'd0, saw_req}, 32'd0);

    // Grant withdrawn for 3 cycles during the read of the second word.
    dropped = 1'b0;
    fork
      run_xfer(20'h00040, 20'h00500, 16'd4, 1'b0, 16'h0);
      begin
        for (int k = 0; k < 40 && !dropped; k++) begin
          @(posedge clk); #1;
          if (read === 1'b1 && write === 1'b0 && bus_addr === 20'h00041) begin
            bus_grant = 1'b0;
            repeat (3) @(posedge clk);
            #1 bus_grant = 1'b1;
            dropped = 1'b1;
          end
        end
      end
    join
    chk("drop_happened", {31'd0, dropped}, 32'd1);
    chk("drop_done_edge", 32'(last_done_edge), 32'd14);
    chk("drop_word1", {16'd0, mem[20'h00501]}, 32'h1041);

    // Source pointer wraps past the top of the address space.
    run_xfer(20'hFFFFE, 20'h00600, 16'd4, 1'b0, 16'h0);
    chk("wrap_done_edge", 32'(last_done_edge), 32'd10);
    chk("wrap_rd_count", 32'(rd_addrs.size()), 32'd4);
    if (rd_addrs.size() == 4) begin
      chk("wrap_rd0", {12'd0, rd_addrs[0]}, 32'h000FFFFE);
      chk("wrap_rd1", {12'd0, rd_addrs[1]}, 32'h000FFFFF);
      chk("wrap_rd2", {12'd0, rd_addrs[2]}, 32'h00000000);
      chk("wrap_rd3", {12'd0, rd_addrs[3]}, 32'h00000001);
    end
    chk("wrap_word2", {16'd0, mem[20'h00602]}, 32'h1000);

    // Asynchronous reset during a write.
    ops_check = 1'b0;
    @(posedge clk); #1;
    src_addr = 20'h00030; dst_addr = 20'h00300; length = 16'd4; start = 1'b1;
`ifdef DMA_FILL_EN
    fill_mode = 1'b0;
`endif
    @(posedge clk); #1;
    start = 1'b0;
    begin
      automatic bit in_wr = 1'b0;
      for (int k = 0; k < 20 && !in_wr; k++) begin
        @(negedge clk);
        if (write === 1'b1 && read === 1'b0) in_wr = 1'b1;
      end
      chk("rst_reached_wr", {31'd0, in_wr}, 32'd1);
    end
    #1 reset = 1'b1;
    #1;
    chk("rst_bus_released", {30'd0, read, write}, 32'd3);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_write_not_committed", {16'd0, mem[20'h00300]}, 32'h1300);
    repeat (4) begin
      @(negedge clk);
      chk("rst_no_done", {31'd0, done}, 32'd0);
      chk("rst_stays_idle", {31'd0, busy}, 32'd0);
    end
    ops_check = 1'b1;

`ifdef DMA_FILL_EN
    run_xfer(20'h00000, 20'h00200, 16'd3, 1'b1, 16'hA5A5);
    chk("fill_done_edge", 32'(last_done_edge), 32'd5);
    chk("fill_no_read", {31'd0, saw_read}, 32'd0);
    chk("fill_word0", {16'd0, mem[20'h00200]}, 32'hA5A5);
    chk("fill_word2", {16'd0, mem[20'h00202]}, 32'hA5A5);
`endif

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
